// File: rtl/issue_queue_alu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : issue_queue_alu_if
// Description : Dispatch, grant, wakeup and entry-readout signals of the ALU
//               issue queue. The master drives dispatch, flush, grant and
//               wakeup; the slave (the queue) returns status and entry contents.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface issue_queue_alu_if;
  logic        flush;
  logic        disp_en;
  logic [20:0] disp_data;
  logic        disp_ack;
  logic        full;
  logic [2:0]  count;
  logic [6:0]  select_en;
  logic [4:0]  wakeup_reg_ALU0;
  logic [4:0]  wakeup_reg_ALU1;
  logic [4:0]  wakeup_reg_MD;
  logic [4:0]  wakeup_reg_LS;
  logic        wakeup_ALU_en0;
  logic        wakeup_ALU_en1;
  logic        wakeup_MD_en;
  logic        wakeup_LS_en;
  logic [20:0] IQ_ALU_dout0;
  logic [20:0] IQ_ALU_dout1;
  logic [20:0] IQ_ALU_dout2;
  logic [20:0] IQ_ALU_dout3;
  logic [20:0] IQ_ALU_dout4;
  logic [20:0] IQ_ALU_dout5;
  logic [20:0] IQ_ALU_dout6;

  modport master (
    output flush, disp_en, disp_data, select_en,
    output wakeup_reg_ALU0, wakeup_reg_ALU1, wakeup_reg_MD, wakeup_reg_LS,
    output wakeup_ALU_en0, wakeup_ALU_en1, wakeup_MD_en, wakeup_LS_en,
    input  disp_ack, full, count,
    input  IQ_ALU_dout0, IQ_ALU_dout1, IQ_ALU_dout2, IQ_ALU_dout3,
    input  IQ_ALU_dout4, IQ_ALU_dout5, IQ_ALU_dout6
  );

  modport slave (
    input  flush, disp_en, disp_data, select_en,
    input  wakeup_reg_ALU0, wakeup_reg_ALU1, wakeup_reg_MD, wakeup_reg_LS,
    input  wakeup_ALU_en0, wakeup_ALU_en1, wakeup_MD_en, wakeup_LS_en,
    output disp_ack, full, count,
    output IQ_ALU_dout0, IQ_ALU_dout1, IQ_ALU_dout2, IQ_ALU_dout3,
    output IQ_ALU_dout4, IQ_ALU_dout5, IQ_ALU_dout6
  );
endinterface
`default_nettype wire

// File: rtl/issue_queue_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : issue_queue_alu
// Description : 7-entry compacting ALU issue queue. Entries are kept in age
//               order in slots 0..count-1; granted entries are squeezed out,
//               survivors shift down and a new dispatch lands just above them.
//               Source ready bits are set by four wakeup tag buses, including
//               a bypass into the entry being dispatched in the same cycle.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module issue_queue_alu #(
  parameter int DEPTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  issue_queue_alu_if.slave   bus
);

  localparam int c_VALID_BIT = 15;
  localparam int c_S1RDY_BIT = 14;
  localparam int c_S2RDY_BIT = 7;

  logic [20:0] r_entry [DEPTH];
  logic [2:0]  r_count;
  logic [20:0] w_next [DEPTH];
  logic [2:0]  w_count_next;
  logic        w_ack;
  logic [3:0]  w_wake_en;
  logic [19:0] w_wake_tag;

  assign w_wake_en  = {bus.wakeup_LS_en, bus.wakeup_MD_en,
                       bus.wakeup_ALU_en1, bus.wakeup_ALU_en0};
  assign w_wake_tag = {bus.wakeup_reg_LS, bus.wakeup_reg_MD,
                       bus.wakeup_reg_ALU1, bus.wakeup_reg_ALU0};

  // True when any enabled wakeup bus carries tag r (tag 0 is not special).
  function automatic logic f_match(input logic [4:0]  r,
                                   input logic [3:0]  en,
                                   input logic [19:0] tags);
    logic m;
    m = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (en[b] && (tags[b*5 +: 5] == r)) m = 1'b1;
    end
    return m;
  endfunction

  // Ready bits only ever accumulate; reserved fields are untouched.
  function automatic logic [20:0] f_wake(input logic [20:0] e,
                                         input logic [3:0]  en,
                                         input logic [19:0] tags);
    logic [20:0] o;
    o = e;
    o[c_S1RDY_BIT] = e[c_S1RDY_BIT] | f_match(e[12:8], en, tags);
    o[c_S2RDY_BIT] = e[c_S2RDY_BIT] | f_match(e[4:0], en, tags);
    return o;
  endfunction

  // Full is judged on the current count, so a same-cycle grant never frees
  // room for a dispatch. Reset forces the acknowledge low immediately.
  assign bus.full     = (r_count == 3'd7);
  assign w_ack        = rst_n & bus.disp_en & ~bus.full & ~bus.flush;
  assign bus.disp_ack = w_ack;
  assign bus.count    = r_count;

  // Invalid slots are held at zero in state, so the registers feed dout directly.
  assign bus.IQ_ALU_dout0 = r_entry[0];
  assign bus.IQ_ALU_dout1 = r_entry[1];
  assign bus.IQ_ALU_dout2 = r_entry[2];
  assign bus.IQ_ALU_dout3 = r_entry[3];
  assign bus.IQ_ALU_dout4 = r_entry[4];
  assign bus.IQ_ALU_dout5 = r_entry[5];
  assign bus.IQ_ALU_dout6 = r_entry[6];

  // Next state: drop granted valid slots, compact survivors, append dispatch.
  always_comb begin
    logic [3:0]  v_n;
    logic [20:0] v_disp;
    for (int i = 0; i < DEPTH; i++) w_next[i] = '0;
    v_n    = 4'd0;
    v_disp = bus.disp_data;
    v_disp[c_VALID_BIT] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_entry[i][c_VALID_BIT] && !bus.select_en[i]) begin
        w_next[v_n[2:0]] = f_wake(r_entry[i], w_wake_en, w_wake_tag);
        v_n = v_n + 4'd1;
      end
    end
    // An acknowledged dispatch implies fewer than 7 survivors, so v_n <= 6.
    if (w_ack) begin
      w_next[v_n[2:0]] = f_wake(v_disp, w_wake_en, w_wake_tag);
    end
    w_count_next = v_n[2:0] + {2'b00, w_ack};
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) w_next[i] = '0;
      w_count_next = 3'd0;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_count <= 3'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= w_next[i];
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire
